// File: rtl/run_length_guard_if.sv
// Bundles the trigger/channel inputs and verdict outputs of the run-length guard.
// The master drives the trigger side and observes the verdicts. The slave is the checker itself.
interface run_length_guard_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             start;
  logic [CH-1:0]    a;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [CH-1:0]    fail_mask;
  logic [CNT_W-1:0] fail_count;

  modport master (
    output clear, start, a,
    input  busy, pass, fail, fail_mask, fail_count
  );

  modport slave (
    input  clear, start, a,
    output busy, pass, fail, fail_mask, fail_count
  );
endinterface

// File: rtl/run_length_guard.sv
// Multi-channel "not a[*RUN_LEN]" monitor. A rising edge on start opens a
// window of WINDOW cycles beginning on the following edge. A channel that is
// high for RUN_LEN consecutive window cycles fails the window. A window that
// completes without such a run passes.
module run_length_guard #(
  parameter int CH        = 4,
  parameter int RUN_LEN   = 2,
  parameter int WINDOW    = 8,
  parameter int RETRIGGER = 1,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  run_length_guard_if.slave  bus
);

  localparam int RC_W = $clog2(RUN_LEN + 1);
  localparam int WC_W = $clog2(WINDOW + 1);

  // A parameter set that cannot describe a meaningful window is refused at elaboration.
  if (CH < 1 || WINDOW < 1 || RUN_LEN < 1 || RUN_LEN > WINDOW) begin : g_bad_params
    $error("run_length_guard: illegal parameters CH=%0d RUN_LEN=%0d WINDOW=%0d", CH, RUN_LEN, WINDOW);
  end

  typedef enum logic {IDLE, ARMED} state_t;

  state_t                     state_q, state_d;
  logic                       start_q, start_d;
  logic [WC_W-1:0]            win_cnt_q, win_cnt_d;
  logic [CH-1:0][RC_W-1:0]    run_cnt_q, run_cnt_d;
  logic                       busy_q, busy_d;
  logic                       pass_q, pass_d;
  logic                       fail_q, fail_d;
  logic [CH-1:0]              fail_mask_q, fail_mask_d;
  logic [CNT_W-1:0]           fail_count_q, fail_count_d;

  logic                       rise;
  logic [CH-1:0][RC_W-1:0]    nxt;
  logic [CH-1:0]              hit;

  assign rise = bus.start & ~start_q;

  // Per-channel run lengths this edge and which channels just completed a forbidden run.
  always_comb begin
    nxt = '0;
    hit = '0;
    for (int ch = 0; ch < CH; ch++) begin
      nxt[ch] = bus.a[ch] ? run_cnt_q[ch] + 1'b1 : '0;
      hit[ch] = (nxt[ch] == RC_W'(RUN_LEN));
    end
  end

  // Next-state logic. A fail takes priority over a pass on the same edge, and a
  // rise on the deciding edge (or any rise when retriggering) arms a fresh window.
  always_comb begin
    start_d      = bus.start;
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    run_cnt_d    = run_cnt_q;
    pass_d       = 1'b0;
    fail_d       = 1'b0;
    fail_mask_d  = fail_mask_q;
    fail_count_d = fail_count_q;

    if (bus.clear) begin
      state_d      = IDLE;
      win_cnt_d    = '0;
      run_cnt_d    = '0;
      fail_mask_d  = '0;
      fail_count_d = '0;
    end else if (state_q == IDLE) begin
      if (rise) begin
        state_d   = ARMED;
        win_cnt_d = '0;
        run_cnt_d = '0;
      end
    end else begin
      if (|hit) begin
        fail_d      = 1'b1;
        fail_mask_d = hit;
        if (fail_count_q != '1) begin
          fail_count_d = fail_count_q + 1'b1;
        end
        state_d   = IDLE;
        win_cnt_d = '0;
        run_cnt_d = '0;
      end else if (win_cnt_q == WC_W'(WINDOW - 1)) begin
        pass_d    = 1'b1;
        state_d   = IDLE;
        win_cnt_d = '0;
        run_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        run_cnt_d = nxt;
      end
      if (rise && (state_d == IDLE || RETRIGGER != 0)) begin
        state_d   = ARMED;
        win_cnt_d = '0;
        run_cnt_d = '0;
      end
    end

    busy_d = (state_d == ARMED);
  end

  // All state, including the verdict outputs, is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      win_cnt_q    <= '0;
      run_cnt_q    <= '0;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_mask_q  <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      win_cnt_q    <= win_cnt_d;
      run_cnt_q    <= run_cnt_d;
      busy_q       <= busy_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      fail_mask_q  <= fail_mask_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.fail_mask  = fail_mask_q;
  assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_run_length_guard.sv
// Drives three guards from one shared stimulus stream:
//   inst0: CH=4 RUN_LEN=3 WINDOW=8 RETRIGGER=1
//   inst1: CH=4 RUN_LEN=3 WINDOW=8 RETRIGGER=0
//   inst2: CH=1 RUN_LEN=2 WINDOW=2 RETRIGGER=1 (sees a[0])
// A reference model keeps the raw sample history of each open window and judges
// runs by scanning the last RUN_LEN samples.
module tb_run_length_guard;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       start;
  logic [3:0] a;

  int n_cmp = 0;
  int n_err = 0;

  run_length_guard_if #(.CH(4), .CNT_W(8)) if0 ();
  run_length_guard_if #(.CH(4), .CNT_W(8)) if1 ();
  run_length_guard_if #(.CH(1), .CNT_W(8)) if2 ();

  assign if0.clear = clear;
  assign if0.start = start;
  assign if0.a     = a;
  assign if1.clear = clear;
  assign if1.start = start;
  assign if1.a     = a;
  assign if2.clear = clear;
  assign if2.start = start;
  assign if2.a     = a[0];

  run_length_guard #(.CH(4), .RUN_LEN(3), .WINDOW(8), .RETRIGGER(1), .CNT_W(8))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  run_length_guard #(.CH(4), .RUN_LEN(3), .WINDOW(8), .RETRIGGER(0), .CNT_W(8))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  run_length_guard #(.CH(1), .RUN_LEN(2), .WINDOW(2), .RETRIGGER(1), .CNT_W(8))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Configuration of each instance as seen by the model.
  int rl  [3] = '{3, 3, 2};
  int wn  [3] = '{8, 8, 2};
  int rt  [3] = '{1, 0, 1};
  int chn [3] = '{4, 4, 1};

  // Model state: open windows and the samples taken inside them.
  bit         m_start_prev;
  bit         m_armed [3];
  int         m_len   [3];
  logic [3:0] m_hist  [3][8];

  // Expected registered outputs.
  logic       exp_busy [3];
  logic       exp_pass [3];
  logic       exp_fail [3];
  logic [3:0] exp_mask [3];
  int         exp_cnt  [3];

  task automatic modelReset();
    m_start_prev = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_armed[i]  = 1'b0;
      m_len[i]    = 0;
      exp_busy[i] = 1'b0;
      exp_pass[i] = 1'b0;
      exp_fail[i] = 1'b0;
      exp_mask[i] = 4'b0;
      exp_cnt[i]  = 0;
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs present at that edge.
  task automatic modelEdge();
    bit         rise;
    bit         decided;
    bit         run;
    logic [3:0] viol;
    rise = start && !m_start_prev;
    m_start_prev = start;
    for (int i = 0; i < 3; i++) begin
      exp_pass[i] = 1'b0;
      exp_fail[i] = 1'b0;
      if (clear) begin
        m_armed[i]  = 1'b0;
        m_len[i]    = 0;
        exp_mask[i] = 4'b0;
        exp_cnt[i]  = 0;
      end else if (!m_armed[i]) begin
        if (rise) begin
          m_armed[i] = 1'b1;
          m_len[i]   = 0;
        end
      end else begin
        decided = 1'b0;
        m_hist[i][m_len[i]] = a;
        m_len[i]++;
        viol = 4'b0;
        if (m_len[i] >= rl[i]) begin
          for (int ch = 0; ch < chn[i]; ch++) begin
            run = 1'b1;
            for (int k = m_len[i] - rl[i]; k < m_len[i]; k++) begin
              if (!m_hist[i][k][ch]) run = 1'b0;
            end
            viol[ch] = run;
          end
        end
        if (viol != 4'b0) begin
          exp_fail[i] = 1'b1;
          exp_mask[i] = viol;
          if (exp_cnt[i] < 255) exp_cnt[i]++;
          decided = 1'b1;
        end else if (m_len[i] == wn[i]) begin
          exp_pass[i] = 1'b1;
          decided = 1'b1;
        end
        if (decided) begin
          m_armed[i] = 1'b0;
          m_len[i]   = 0;
        end
        if (rise && (decided || rt[i] == 1)) begin
          m_armed[i] = 1'b1;
          m_len[i]   = 0;
        end
      end
      exp_busy[i] = m_armed[i];
    end
  endtask

  task automatic cmp(input string tag, input int inst, input string what,
                     input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("[TB] FAIL %s inst%0d %s observed=%0h expected=%0h", tag, inst, what, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic       b, p, f;
    logic [3:0] m;
    logic [7:0] c;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin b = if0.busy; p = if0.pass; f = if0.fail; m = if0.fail_mask; c = if0.fail_count; end
        1: begin b = if1.busy; p = if1.pass; f = if1.fail; m = if1.fail_mask; c = if1.fail_count; end
        default: begin b = if2.busy; p = if2.pass; f = if2.fail; m = {3'b000, if2.fail_mask}; c = if2.fail_count; end
      endcase
      cmp(tag, i, "busy", {7'b0, b}, {7'b0, exp_busy[i]});
      cmp(tag, i, "pass", {7'b0, p}, {7'b0, exp_pass[i]});
      cmp(tag, i, "fail", {7'b0, f}, {7'b0, exp_fail[i]});
      cmp(tag, i, "fail_mask", {4'b0, m}, {4'b0, exp_mask[i]});
      cmp(tag, i, "fail_count", c, 8'(exp_cnt[i]));
    end
  endtask

  // Inputs change just after a checked edge and stay stable through the next edge.
  task automatic applyStimulus(input logic c, input logic s, input logic [3:0] av, input string tag);
    clear = c;
    start = s;
    a     = av;
    @(posedge clk);
    if (rst_n) modelEdge();
    else       modelReset();
    #1;
    checkOutput(tag);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    a     = 4'b0;
    modelReset();
    #3;
    checkOutput("reset");
    #9 rst_n = 1'b1;

    // Small window: rise on edge 3, a high on edges 4 and 5 -> fail after edge 5.
    applyStimulus(0, 0, 4'h0, "t1_e1");
    applyStimulus(0, 0, 4'h0, "t1_e2");
    applyStimulus(0, 1, 4'h0, "t1_rise");
    applyStimulus(0, 0, 4'h1, "t1_w1");
    applyStimulus(0, 0, 4'h1, "t1_w2");
    cmp("t1_fail_pulse", 2, "fail", {7'b0, if2.fail}, 8'h01);
    cmp("t1_fail_count", 2, "fail_count", if2.fail_count, 8'h01);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 4'h0, "t1_drain");

    // Small window: a high on the first window edge only -> pass.
    applyStimulus(0, 1, 4'h0, "t2_rise");
    applyStimulus(0, 0, 4'h1, "t2_w1");
    applyStimulus(0, 0, 4'h0, "t2_w2");
    cmp("t2_pass_pulse", 2, "pass", {7'b0, if2.pass}, 8'h01);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 4'h0, "t2_drain");

    // Channels 0 and 2 high on T+2..T+4 -> single fail with both channels flagged.
    applyStimulus(0, 1, 4'h0, "t3_rise");
    applyStimulus(0, 0, 4'h0, "t3_w1");
    applyStimulus(0, 0, 4'h5, "t3_w2");
    applyStimulus(0, 0, 4'h5, "t3_w3");
    applyStimulus(0, 0, 4'h5, "t3_w4");
    cmp("t3_mask", 0, "fail_mask", {4'b0, if0.fail_mask}, 8'h05);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 4'h0, "t3_drain");

    // Re-rise five edges into a clean window: inst0 restarts, inst1 ignores it.
    applyStimulus(0, 1, 4'h0, "t4_rise");
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 4'h0, "t4_w");
    applyStimulus(0, 1, 4'h0, "t4_rerise");
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 4'h0, "t4_tail");

    // a stuck high across 300 triggers drives every fail counter into saturation.
    for (int t = 0; t < 300; t++) begin
      applyStimulus(0, 1, 4'hF, "t5_rise");
      for (int k = 0; k < 4; k++) applyStimulus(0, 0, 4'hF, "t5_run");
    end
    cmp("t5_saturate", 0, "fail_count", if0.fail_count, 8'hFF);
    applyStimulus(1, 0, 4'h0, "t5_clear");
    cmp("t5_cleared", 0, "fail_count", if0.fail_count, 8'h00);

    // Asynchronous reset in the middle of a window, start held high over release.
    applyStimulus(0, 1, 4'h0, "t6_rise");
    applyStimulus(0, 0, 4'h0, "t6_w1");
    applyStimulus(0, 1, 4'h0, "t6_w2");
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("t6_async");
    @(posedge clk);
    #1;
    checkOutput("t6_hold");
    #2 rst_n = 1'b1;
    applyStimulus(0, 1, 4'h0, "t6_rearm");
    applyStimulus(0, 0, 4'h0, "t6_after");

    // Clear arriving with a rise wins and leaves the guard idle.
    applyStimulus(1, 0, 4'h0, "t7_pre");
    applyStimulus(1, 1, 4'h0, "t7_clear_rise");
    applyStimulus(0, 0, 4'h0, "t7_idle");

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 1500; n++) begin
      logic       rc, rs;
      logic [3:0] ra;
      rc = ($urandom_range(0, 63) == 0);
      rs = ($urandom_range(0, 3) == 0);
      if (n < 750) ra = 4'($urandom);
      else         ra = 4'($urandom | $urandom);
      applyStimulus(rc, rs, ra, "rand");
    end
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 4'h0, "final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
